// File: rtl/unified_mem_arbiter_if.sv
// Bundle of the IF port, the MEM port and the memory-side command/response signals.
// The arbiter uses the slave modport; the core and memory environment use the master modport.
interface unified_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ack;
  logic [DW-1:0] i_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          if_stall;
  logic          mem_stall;
  logic          bus_err;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rvalid, mem_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata,
           if_stall, mem_stall, bus_err
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rvalid, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata,
           if_stall, mem_stall, bus_err
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port variable-latency memory between instruction fetch and data access.
// Optional MEM_TIMEOUT_EN adds a BUSY watchdog that aborts with bus_err after TIMEOUT_CYCLES.
module unified_mem_arbiter #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic                  clk,
  input logic                  rst,
  unified_mem_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  localparam int            SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;

  logic          d_wins;
  logic          timeout_hit;
  logic          mem_req_c;
  logic          mem_we_c;
  logic [AW-1:0] mem_addr_c;
  logic [DW-1:0] mem_wdata_c;
  logic          i_ack_c;
  logic          d_ack_c;
  logic [DW-1:0] i_rdata_c;
  logic [DW-1:0] d_rdata_c;
  logic          bus_err_c;

`ifdef MEM_TIMEOUT_EN
  localparam int            TW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  // Counter sits at zero in IDLE, so every BUSY entry starts from a clean count.
  assign timeout_hit = (state_q != IDLE) && !bus.mem_rvalid && (tmo_cnt_q == TMO_LAST);

  always_comb begin
    tmo_cnt_d = '0;
    if ((state_q != IDLE) && !bus.mem_rvalid && !timeout_hit)
      tmo_cnt_d = tmo_cnt_q + TW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_cnt_q <= '0;
    else     tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    mem_req_c    = 1'b0;
    mem_we_c     = 1'b0;
    mem_addr_c   = '0;
    mem_wdata_c  = '0;
    i_ack_c      = 1'b0;
    d_ack_c      = 1'b0;
    i_rdata_c    = '0;
    d_rdata_c    = '0;
    bus_err_c    = 1'b0;
    // Data wins unless fetch has already lost STARVE_LIMIT rounds in a row.
    d_wins       = bus.d_req & ~(bus.i_req & (starve_cnt_q == STARVE_MAX));

    case (state_q)
      IDLE: begin
        if (bus.i_req | bus.d_req) begin
          mem_req_c = 1'b1;
          if (d_wins) begin
            mem_we_c    = bus.d_we;
            mem_addr_c  = bus.d_addr;
            mem_wdata_c = bus.d_wdata;
            state_d     = BUSY_D;
            if (bus.i_req && (starve_cnt_q != STARVE_MAX))
              starve_cnt_d = starve_cnt_q + SW'(1);
          end else begin
            mem_addr_c   = bus.i_addr;
            state_d      = BUSY_I;
            starve_cnt_d = '0;
          end
        end
      end
      BUSY_I: begin
        if (bus.mem_rvalid || timeout_hit) begin
          i_ack_c   = 1'b1;
          i_rdata_c = bus.mem_rvalid ? bus.mem_rdata : '0;
          bus_err_c = timeout_hit;
          state_d   = IDLE;
        end
      end
      BUSY_D: begin
        if (bus.mem_rvalid || timeout_hit) begin
          d_ack_c   = 1'b1;
          d_rdata_c = bus.mem_rvalid ? bus.mem_rdata : '0;
          bus_err_c = timeout_hit;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // The command strobe is combinational from the requests, so hold it quiet while in reset.
  assign bus.mem_req   = mem_req_c & ~rst;
  assign bus.mem_we    = mem_we_c & ~rst;
  assign bus.mem_addr  = rst ? '0 : mem_addr_c;
  assign bus.mem_wdata = rst ? '0 : mem_wdata_c;
  assign bus.i_ack     = i_ack_c;
  assign bus.d_ack     = d_ack_c;
  assign bus.i_rdata   = i_rdata_c;
  assign bus.d_rdata   = d_rdata_c;
  assign bus.bus_err   = bus_err_c;
  assign bus.if_stall  = bus.i_req & ~i_ack_c;
  assign bus.mem_stall = bus.d_req & ~d_ack_c;

endmodule
